// File: rtl/pio_input_poller.sv
// pio_input_poller
//    Avalon-MM read initiator that periodically reads the data register
//    (address 0) of an input PIO responder and publishes every sample that
//    differs from the previous one on a valid/ready change stream.
//
// Parameters
//    DATA_W        width of the PIO data field (readdata[DATA_W-1:0])
//    ADDR_W        Avalon address width of the polled responder
//    POLL_DIV      idle cycles between the end of one poll and the next (>=1)
//    READ_LATENCY  fixed cycles from command acceptance to valid readdata (>=1)
//
// Ports
//    clk, reset_n        system clock, asynchronous active-low reset
//    enable              polling enable
//    avm_address         read address, always 0
//    avm_read            read command, held until accepted
//    avm_waitrequest     fabric stall
//    avm_readdata        read data from the responder
//    chg_data, chg_valid new input value and its valid flag
//    chg_ready           consumer accepts chg_data
//    overrun             sticky: a change was overwritten before consumption
//    overrun_clr         clears overrun (a simultaneous set wins)
//    irq                 only with PIO_POLL_IRQ_EN: registered chg_valid | overrun
//
// Optional feature macro: PIO_POLL_IRQ_EN

module pio_input_poller #(
   parameter int DATA_W       = 8,
   parameter int ADDR_W       = 2,
   parameter int POLL_DIV     = 1000,
   parameter int READ_LATENCY = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   output logic [DATA_W-1:0] chg_data,
   output logic              chg_valid,
   input  logic              chg_ready,
   output logic              overrun,
   input  logic              overrun_clr
`ifdef PIO_POLL_IRQ_EN
   ,
   output logic              irq
`endif
);

   localparam int CNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] POLL_RELOAD = CNT_W'(POLL_DIV - 1);
   localparam logic [LAT_W-1:0] LAT_RELOAD  = LAT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_CAPTURE
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
   logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
   logic [DATA_W-1:0] sample_q, sample_d;
   logic [DATA_W-1:0] last_value_q, last_value_d;
   logic              first_q, first_d;
   logic              avm_read_q, avm_read_d;
   logic [DATA_W-1:0] chg_data_q, chg_data_d;
   logic              chg_valid_q, chg_valid_d;
   logic              overrun_q, overrun_d;
   logic              report;
   logic              overrun_set;

   // The address never changes, so it is a constant tie rather than a flop.
   assign avm_address = '0;
   assign avm_read    = avm_read_q;
   assign chg_data    = chg_data_q;
   assign chg_valid   = chg_valid_q;
   assign overrun     = overrun_q;

   // Bits above the data field are deliberately ignored.
   generate
      if (DATA_W < 32) begin : g_unused_hi
         logic unused_hi;
         assign unused_hi = ^avm_readdata[31:DATA_W];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         poll_cnt_q   <= POLL_RELOAD;
         lat_cnt_q    <= '0;
         sample_q     <= '0;
         last_value_q <= '0;
         first_q      <= 1'b1;
         avm_read_q   <= 1'b0;
         chg_data_q   <= '0;
         chg_valid_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         poll_cnt_q   <= poll_cnt_d;
         lat_cnt_q    <= lat_cnt_d;
         sample_q     <= sample_d;
         last_value_q <= last_value_d;
         first_q      <= first_d;
         avm_read_q   <= avm_read_d;
         chg_data_q   <= chg_data_d;
         chg_valid_q  <= chg_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   // Poll sequencer. avm_read is raised on the way into REQ so that it is a
   // registered output; once the transaction has started it always runs to
   // CAPTURE regardless of enable.
   always_comb begin
      state_d      = state_q;
      poll_cnt_d   = poll_cnt_q;
      lat_cnt_d    = lat_cnt_q;
      sample_d     = sample_q;
      last_value_d = last_value_q;
      first_d      = first_q;
      avm_read_d   = avm_read_q;
      report       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!enable) begin
               poll_cnt_d = POLL_RELOAD;
            end else if (poll_cnt_q == '0) begin
               state_d    = S_REQ;
               avm_read_d = 1'b1;
            end else begin
               poll_cnt_d = poll_cnt_q - CNT_W'(1);
            end
         end
         S_REQ: begin
            if (!avm_waitrequest) begin
               avm_read_d = 1'b0;
               lat_cnt_d  = LAT_RELOAD;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (lat_cnt_q == '0) begin
               sample_d = avm_readdata[DATA_W-1:0];
               state_d  = S_CAPTURE;
            end else begin
               lat_cnt_d = lat_cnt_q - LAT_W'(1);
            end
         end
         S_CAPTURE: begin
            report       = (sample_q != last_value_q) || first_q;
            last_value_d = sample_q;
            first_d      = 1'b0;
            poll_cnt_d   = POLL_RELOAD;
            state_d      = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Change stream: a new report always overwrites chg_data (newest wins);
   // if the previous value was still pending and not being taken this cycle,
   // the loss is recorded in the sticky overrun flag, which beats a clear.
   always_comb begin
      chg_data_d  = chg_data_q;
      chg_valid_d = chg_valid_q & ~chg_ready;
      overrun_set = 1'b0;
      if (report) begin
         chg_data_d  = sample_q;
         chg_valid_d = 1'b1;
         overrun_set = chg_valid_q & ~chg_ready;
      end
      if (overrun_set) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end else begin
         overrun_d = overrun_q;
      end
   end

`ifdef PIO_POLL_IRQ_EN
   logic irq_q, irq_d;

   assign irq   = irq_q;
   assign irq_d = chg_valid_q | overrun_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end
`endif

endmodule

// File: tb/tb_pio_input_poller.sv
// tb_pio_input_poller
//    Directed self-checking bench for pio_input_poller. Two instances share
//    clk and reset_n: dut (POLL_DIV=4, READ_LATENCY=1) and dut3
//    (POLL_DIV=4, READ_LATENCY=3). Each has a small responder model that
//    drives readdata only in the cycle the poller should sample it and a
//    recognisable garbage value otherwise.

module tb_pio_input_poller;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic [1:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic [7:0]  chg_data;
   logic        chg_valid;
   logic        chg_ready;
   logic        overrun;
   logic        overrun_clr;

   logic        enable3;
   logic [1:0]  avm_address3;
   logic        avm_read3;
   logic [31:0] avm_readdata3;
   logic [7:0]  chg_data3;
   logic        chg_valid3;
   logic        chg_ready3;
   logic        overrun3;

`ifdef PIO_POLL_IRQ_EN
   logic        irq;
   logic        irq3;
`endif

   logic [7:0]  pio;
   logic [31:0] pio3;
   logic [2:0]  pipe3 = '0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pio_input_poller #(
      .DATA_W(8), .ADDR_W(2), .POLL_DIV(4), .READ_LATENCY(1)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable),
      .avm_address     (avm_address),
      .avm_read        (avm_read),
      .avm_waitrequest (avm_waitrequest),
      .avm_readdata    (avm_readdata),
      .chg_data        (chg_data),
      .chg_valid       (chg_valid),
      .chg_ready       (chg_ready),
      .overrun         (overrun),
      .overrun_clr     (overrun_clr)
`ifdef PIO_POLL_IRQ_EN
      ,
      .irq             (irq)
`endif
   );

   pio_input_poller #(
      .DATA_W(8), .ADDR_W(2), .POLL_DIV(4), .READ_LATENCY(3)
   ) dut3 (
      .clk             (clk),
      .reset_n         (reset_n),
      .enable          (enable3),
      .avm_address     (avm_address3),
      .avm_read        (avm_read3),
      .avm_waitrequest (1'b0),
      .avm_readdata    (avm_readdata3),
      .chg_data        (chg_data3),
      .chg_valid       (chg_valid3),
      .chg_ready       (chg_ready3),
      .overrun         (overrun3),
      .overrun_clr     (1'b0)
`ifdef PIO_POLL_IRQ_EN
      ,
      .irq             (irq3)
`endif
   );

   // Latency-1 responder: registers the PIO value on the acceptance edge,
   // garbage on every other edge, so an early or late sample is visible.
   always @(posedge clk) begin
      if (avm_read && !avm_waitrequest) begin
         avm_readdata <= {24'hF0F0F0, pio};
      end else begin
         avm_readdata <= 32'h5A5A_5AC3;
      end
   end

   // Latency-3 responder: data valid only in the third cycle after acceptance.
   always @(posedge clk) begin
      pipe3 <= {pipe3[1:0], avm_read3};
   end
   assign avm_readdata3 = pipe3[2] ? pio3 : 32'h0000_00A5;

   // Watchdog so the bench always ends even if a wait loop is broken.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Ticks until the selected poller shows avm_read=1; n is the number of
   // ticks taken, or -1 if the bound expired.
   task automatic wait_read(input bit use3, output int n);
      n = -1;
      for (int i = 1; i <= 60; i++) begin
         tick();
         if ((use3 ? avm_read3 : avm_read) === 1'b1) begin
            n = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      reset_n         = 1'b0;
      enable          = 1'b0;
      avm_waitrequest = 1'b0;
      chg_ready       = 1'b0;
      overrun_clr     = 1'b0;
      pio             = 8'h00;
      enable3         = 1'b0;
      chg_ready3      = 1'b0;
      pio3            = 32'h0;
      repeat (3) tick();
      total++;
      if (avm_read !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_read: got %b expected 0", avm_read);
      end
      total++;
      if (avm_address !== 2'b00) begin
         bad++; $display("[TB] FAIL reset_addr: got %h expected 0", avm_address);
      end
      total++;
      if (chg_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_valid: got %b expected 0", chg_valid);
      end
      total++;
      if (chg_data !== 8'h00) begin
         bad++; $display("[TB] FAIL reset_data: got %h expected 00", chg_data);
      end
      total++;
      if (overrun !== 1'b0) begin
         bad++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun);
      end
   endtask

   task automatic test_first_sample();
      bit early;
      int vcount;
      enable  = 1'b1;
      pio     = 8'h00;
      reset_n = 1'b1;
      early   = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (avm_read !== 1'b0) early = 1'b1;
      end
      total++;
      if (early !== 1'b0) begin
         bad++; $display("[TB] FAIL first_read_early: got %b expected 0", early);
      end
      tick();
      total++;
      if (avm_read !== 1'b1) begin
         bad++; $display("[TB] FAIL first_read_at4: got %b expected 1", avm_read);
      end
      repeat (3) tick();
      total++;
      if (chg_valid !== 1'b1 || chg_data !== 8'h00) begin
         bad++; $display("[TB] FAIL first_report: got valid=%b data=%h expected valid=1 data=00",
                         chg_valid, chg_data);
      end
      chg_ready = 1'b1;
      tick();
      total++;
      if (chg_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL first_consume: got %b expected 0", chg_valid);
      end
      vcount = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (chg_valid === 1'b1) vcount++;
      end
      total++;
      if (vcount !== 0) begin
         bad++; $display("[TB] FAIL same_no_report: got %0d valid cycles expected 0", vcount);
      end
   endtask

   task automatic test_change();
      int n;
      int pulses;
      logic [7:0] seen;
      bit ovr;
      pio       = 8'h5A;
      chg_ready = 1'b1;
      wait_read(1'b0, n);
      total++;
      if (n < 0) begin
         bad++; $display("[TB] FAIL change_read_timeout: got %0d expected >0", n);
      end
      pulses = 0;
      seen   = 8'h00;
      ovr    = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (chg_valid === 1'b1) begin
            pulses++;
            seen = chg_data;
         end
         if (overrun !== 1'b0) ovr = 1'b1;
      end
      total++;
      if (pulses !== 1) begin
         bad++; $display("[TB] FAIL change_pulses: got %0d expected 1", pulses);
      end
      total++;
      if (seen !== 8'h5A) begin
         bad++; $display("[TB] FAIL change_data: got %h expected 5a", seen);
      end
      total++;
      if (ovr !== 1'b0) begin
         bad++; $display("[TB] FAIL change_overrun: got %b expected 0", ovr);
      end
      wait_read(1'b0, n);
      total++;
      if (6 + n !== 7) begin
         bad++; $display("[TB] FAIL read_spacing: got %0d expected 7", 6 + n);
      end
   endtask

   task automatic test_overrun();
      int n;
      chg_ready = 1'b0;
      pio       = 8'h11;
      repeat (3) tick();
      total++;
      if (chg_valid !== 1'b1 || chg_data !== 8'h11 || overrun !== 1'b0) begin
         bad++; $display("[TB] FAIL ovr_first: got valid=%b data=%h ovr=%b expected 1 11 0",
                         chg_valid, chg_data, overrun);
      end
      repeat (2) tick();
      total++;
      if (chg_data !== 8'h11) begin
         bad++; $display("[TB] FAIL ovr_stable: got %h expected 11", chg_data);
      end
      pio = 8'h22;
      wait_read(1'b0, n);
      repeat (3) tick();
      total++;
      if (chg_valid !== 1'b1 || chg_data !== 8'h22 || overrun !== 1'b1) begin
         bad++; $display("[TB] FAIL ovr_second: got valid=%b data=%h ovr=%b expected 1 22 1",
                         chg_valid, chg_data, overrun);
      end
      overrun_clr = 1'b1;
      tick();
      overrun_clr = 1'b0;
      total++;
      if (overrun !== 1'b0 || chg_valid !== 1'b1) begin
         bad++; $display("[TB] FAIL ovr_clear: got ovr=%b valid=%b expected 0 1", overrun, chg_valid);
      end
      chg_ready = 1'b1;
      tick();
      total++;
      if (chg_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL ovr_consume: got %b expected 0", chg_valid);
      end
   endtask

   task automatic test_waitrequest();
      int n;
      bit held;
      pio             = 8'h77;
      avm_waitrequest = 1'b1;
      wait_read(1'b0, n);
      held = (n > 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (avm_read !== 1'b1 || avm_address !== 2'b00) held = 1'b0;
      end
      total++;
      if (held !== 1'b1) begin
         bad++; $display("[TB] FAIL stall_hold: got %b expected 1", held);
      end
      avm_waitrequest = 1'b0;
      tick();
      total++;
      if (avm_read !== 1'b0) begin
         bad++; $display("[TB] FAIL stall_release: got %b expected 0", avm_read);
      end
      repeat (2) tick();
      total++;
      if (chg_valid !== 1'b1 || chg_data !== 8'h77) begin
         bad++; $display("[TB] FAIL stall_data: got valid=%b data=%h expected 1 77",
                         chg_valid, chg_data);
      end
      tick();
      total++;
      if (chg_valid !== 1'b0) begin
         bad++; $display("[TB] FAIL stall_consume: got %b expected 0", chg_valid);
      end
   endtask

   task automatic test_enable_drop();
      int n;
      int reads;
      chg_ready = 1'b0;
      pio       = 8'h33;
      wait_read(1'b0, n);
      tick();
      enable = 1'b0;
      repeat (2) tick();
      total++;
      if (chg_valid !== 1'b1 || chg_data !== 8'h33) begin
         bad++; $display("[TB] FAIL endrop_report: got valid=%b data=%h expected 1 33",
                         chg_valid, chg_data);
      end
      reads = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (avm_read === 1'b1) reads++;
      end
      total++;
      if (reads !== 0) begin
         bad++; $display("[TB] FAIL endrop_no_read: got %0d expected 0", reads);
      end
      enable = 1'b1;
      wait_read(1'b0, n);
      total++;
      if (n !== 4) begin
         bad++; $display("[TB] FAIL endrop_restart: got %0d expected 4", n);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      pio = 8'h44;
      tick();
      reset_n = 1'b0;
      #1;
      total++;
      if (chg_valid !== 1'b0 || avm_read !== 1'b0 || overrun !== 1'b0) begin
         bad++; $display("[TB] FAIL midreset_clear: got valid=%b read=%b ovr=%b expected 0 0 0",
                         chg_valid, avm_read, overrun);
      end
      tick();
      pio     = 8'h00;
      reset_n = 1'b1;
      wait_read(1'b0, n);
      total++;
      if (n !== 4) begin
         bad++; $display("[TB] FAIL midreset_restart: got %0d expected 4", n);
      end
      repeat (3) tick();
      total++;
      if (chg_valid !== 1'b1 || chg_data !== 8'h00) begin
         bad++; $display("[TB] FAIL midreset_first: got valid=%b data=%h expected 1 00",
                         chg_valid, chg_data);
      end
   endtask

   task automatic test_latency3();
      int n;
      pio3    = 32'hFFFF_FF3C;
      enable3 = 1'b1;
      wait_read(1'b1, n);
      total++;
      if (n !== 4) begin
         bad++; $display("[TB] FAIL lat3_read: got %0d expected 4", n);
      end
      repeat (4) tick();
      total++;
      if (chg_valid3 !== 1'b0) begin
         bad++; $display("[TB] FAIL lat3_early: got %b expected 0", chg_valid3);
      end
      tick();
      total++;
      if (chg_valid3 !== 1'b1 || chg_data3 !== 8'h3C || overrun3 !== 1'b0) begin
         bad++; $display("[TB] FAIL lat3_data: got valid=%b data=%h ovr=%b expected 1 3c 0",
                         chg_valid3, chg_data3, overrun3);
      end
   endtask

   initial begin
      test_reset();
      test_first_sample();
      test_change();
      test_overrun();
      test_waitrequest();
      test_enable_drop();
      test_reset_mid();
      test_latency3();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
